// File: rtl/brent_kung_pkg.sv
// Shared types and sizing helpers for the sequential Brent-Kung adder.
// The FSM state type and the slice-count / counter-width functions live here.
package brent_kung_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StCalc,
        StDone
    } bk_state_e;

    function automatic int unsigned slice_count(input int unsigned adder_size,
                                                 input int unsigned slice_size);
        return adder_size / slice_size;
    endfunction

    // Counter needs at least one bit even when there is only one slice.
    function automatic int unsigned cnt_width(input int unsigned nslice);
        return (nslice > 1) ? $clog2(nslice) : 1;
    endfunction

endpackage

// File: rtl/brent_kung_adder_nbit.sv
// Combinational Brent-Kung parallel-prefix adder of WIDTH bits with carry-in.
// WIDTH must be a power of two.
module brent_kung_adder_nbit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int LEVELS = $clog2(WIDTH);
    localparam int W      = int'(WIDTH);

    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] gp;
    logic [WIDTH-1:0] pp;

    assign p = a ^ b;

    always_comb begin
        gp    = a & b;
        pp    = p;
        // Folding cin into bit 0 makes every prefix gp[i] the carry out of bit i.
        gp[0] = gp[0] | (p[0] & cin);

        // Up-sweep: build group terms at positions 2^(l+1)-1 within each block.
        for (int l = 0; l < LEVELS; l++) begin
            for (int i = 0; i < W; i++) begin
                if (((i + 1) % (2 << l)) == 0) begin
                    gp[i] = gp[i] | (pp[i] & gp[i - (1 << l)]);
                    pp[i] = pp[i] & pp[i - (1 << l)];
                end
            end
        end

        // Down-sweep: fill the remaining positions from completed prefixes.
        for (int l = LEVELS - 2; l >= 0; l--) begin
            for (int i = 0; i < W; i++) begin
                if ((((i + 1) % (2 << l)) == (1 << l)) && (i >= (2 << l))) begin
                    gp[i] = gp[i] | (pp[i] & gp[i - (1 << l)]);
                    pp[i] = pp[i] & pp[i - (1 << l)];
                end
            end
        end

        sum    = '0;
        sum[0] = p[0] ^ cin;
        for (int i = 1; i < W; i++) begin
            sum[i] = p[i] ^ gp[i - 1];
        end
        cout = gp[WIDTH-1];
    end

endmodule

// File: rtl/brent_kung_adder_seq.sv
// Sequential add/subtract unit: one SLICE_SIZE-bit Brent-Kung slice per cycle,
// valid/ready handshake on both sides, result held until consumed.
module brent_kung_adder_seq
    import brent_kung_pkg::*;
#(
    parameter int unsigned ADDER_SIZE = 128,
    parameter int unsigned SLICE_SIZE = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [ADDER_SIZE-1:0] in_op1,
    input  logic [ADDER_SIZE-1:0] in_op2,
    input  logic                  cin,
    input  logic                  in_sub,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ADDER_SIZE-1:0] out_res,
    output logic                  cout,
    output logic                  out_ovf
);

    localparam int unsigned NSLICE = slice_count(ADDER_SIZE, SLICE_SIZE);
    localparam int unsigned CW     = cnt_width(NSLICE);
    localparam logic [CW-1:0] LAST = CW'(NSLICE - 1);
    localparam int unsigned MSB    = ADDER_SIZE - 1;

    bk_state_e state_q, state_d;

    logic [CW-1:0]         cnt_q;
    logic [ADDER_SIZE-1:0] a_q;
    logic [ADDER_SIZE-1:0] b_q;
    logic                  carry_q;
    logic [ADDER_SIZE-1:0] res_q;
    logic                  cout_q;
    logic                  ovf_q;

    logic [31:0]           base;
    logic [SLICE_SIZE-1:0] a_sl;
    logic [SLICE_SIZE-1:0] b_sl;
    logic [SLICE_SIZE-1:0] sum_sl;
    logic                  sl_cout;
    logic                  last;

    assign base = 32'(cnt_q) * SLICE_SIZE;
    assign a_sl = a_q[base +: SLICE_SIZE];
    assign b_sl = b_q[base +: SLICE_SIZE];
    assign last = (cnt_q == LAST);

    brent_kung_adder_nbit #(
        .WIDTH (SLICE_SIZE)
    ) u_slice_adder (
        .a    (a_sl),
        .b    (b_sl),
        .cin  (carry_q),
        .sum  (sum_sl),
        .cout (sl_cout)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (in_valid)  state_d = StCalc;
            StCalc:  if (last)      state_d = StDone;
            StDone:  if (out_ready) state_d = StIdle;
            default:                state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            res_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (state_q == StIdle) begin
            if (in_valid) begin
                // Subtract runs as op1 + ~op2 + ~cin so the borrow-in inverts too.
                a_q     <= in_op1;
                b_q     <= in_sub ? ~in_op2 : in_op2;
                carry_q <= cin ^ in_sub;
                cnt_q   <= '0;
            end
        end else if (state_q == StCalc) begin
            res_q[base +: SLICE_SIZE] <= sum_sl;
            carry_q                   <= sl_cout;
            cnt_q                     <= last ? '0 : cnt_q + CW'(1);
            if (last) begin
                cout_q <= sl_cout;
                ovf_q  <= (a_q[MSB] == b_q[MSB]) && (sum_sl[SLICE_SIZE-1] != a_q[MSB]);
            end
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign out_res   = res_q;
    assign cout      = cout_q;
    assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_brent_kung_adder_seq.sv
// Bench for brent_kung_adder_seq at (128,32) and (32,32): directed corner cases,
// backpressure, mid-operation reset and random operations against an arithmetic model.
module tb_brent_kung_adder_seq;

    logic         clk;
    logic         rst_n;
    logic [127:0] op1;
    logic [127:0] op2;
    logic         cin;
    logic         sub;

    logic         iv128, rdy128, vld128, or128, cout128, ovf128;
    logic [127:0] res128;
    logic         iv32, rdy32, vld32, or32, cout32, ovf32;
    logic [31:0]  res32;

    int vectors;
    int miscompares;

    brent_kung_adder_seq #(
        .ADDER_SIZE (128),
        .SLICE_SIZE (32)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (iv128),
        .in_ready  (rdy128),
        .in_op1    (op1),
        .in_op2    (op2),
        .cin       (cin),
        .in_sub    (sub),
        .out_valid (vld128),
        .out_ready (or128),
        .out_res   (res128),
        .cout      (cout128),
        .out_ovf   (ovf128)
    );

    brent_kung_adder_seq #(
        .ADDER_SIZE (32),
        .SLICE_SIZE (32)
    ) dut32 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (iv32),
        .in_ready  (rdy32),
        .in_op1    (op1[31:0]),
        .in_op2    (op2[31:0]),
        .cin       (cin),
        .in_sub    (sub),
        .out_valid (vld32),
        .out_ready (or32),
        .out_res   (res32),
        .cout      (cout32),
        .out_ovf   (ovf32)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: plain w-bit unsigned and signed arithmetic in a wider container.
    task automatic model(input int w, input logic [127:0] a, input logic [127:0] b,
                         input logic c, input logic s, output logic [127:0] r,
                         output logic co, output logic ov);
        logic [129:0]        mask, ua, ub, cc, u;
        logic signed [129:0] sa, sb, sr, lim;
        mask = (130'd1 << w) - 130'd1;
        ua   = {2'b0, a} & mask;
        ub   = {2'b0, b} & mask;
        cc   = {129'b0, c};
        sa   = ua[w-1] ? (ua | ~mask) : ua;
        sb   = ub[w-1] ? (ub | ~mask) : ub;
        if (!s) begin
            u  = ua + ub + cc;
            co = u[w];
            sr = sa + sb + $signed(cc);
        end else begin
            u  = ua - ub - cc;
            co = (ua >= ub + cc);
            sr = sa - sb - $signed(cc);
        end
        r   = u[127:0] & mask[127:0];
        lim = 130'sd1 <<< (w - 1);
        ov  = (sr >= lim) || (sr < -lim);
    endtask

    function automatic logic rdy(input int w);
        return (w == 128) ? rdy128 : rdy32;
    endfunction

    function automatic logic vld(input int w);
        return (w == 128) ? vld128 : vld32;
    endfunction

    function automatic logic [127:0] res(input int w);
        return (w == 128) ? res128 : {96'b0, res32};
    endfunction

    function automatic logic cout_of(input int w);
        return (w == 128) ? cout128 : cout32;
    endfunction

    function automatic logic ovf_of(input int w);
        return (w == 128) ? ovf128 : ovf32;
    endfunction

    task automatic set_iv(input int w, input logic v);
        if (w == 128) iv128 = v;
        else          iv32  = v;
    endtask

    task automatic set_or(input int w, input logic v);
        if (w == 128) or128 = v;
        else          or32  = v;
    endtask

    // One full transaction; 'hold' cycles of backpressure with in_valid pulsed.
    task automatic run_op(input int w, input logic [127:0] a, input logic [127:0] b,
                          input logic c, input logic s, input int hold);
        logic [127:0] er;
        logic         ec, eo;
        int           cyc;
        int           ns;
        model(w, a, b, c, s, er, ec, eo);
        ns  = (w == 128) ? 4 : 1;
        op1 = a;
        op2 = b;
        cin = c;
        sub = s;
        check("idle_in_ready", {127'b0, rdy(w)}, 128'd1);
        set_iv(w, 1'b1);
        @(posedge clk);
        #1;
        set_iv(w, 1'b0);
        cyc = 0;
        while (vld(w) !== 1'b1 && cyc < 50) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check("latency", 128'(cyc), 128'(ns));
        check("res", res(w), er);
        check("cout", {127'b0, cout_of(w)}, {127'b0, ec});
        check("ovf", {127'b0, ovf_of(w)}, {127'b0, eo});
        for (int i = 0; i < hold; i++) begin
            set_iv(w, 1'b1);
            op1 = ~a;
            @(posedge clk);
            #1;
            check("hold_valid", {127'b0, vld(w)}, 128'd1);
            check("hold_ready", {127'b0, rdy(w)}, 128'd0);
            check("hold_res", res(w), er);
            check("hold_cout", {127'b0, cout_of(w)}, {127'b0, ec});
        end
        set_or(w, 1'b1);
        @(posedge clk);
        #1;
        set_or(w, 1'b0);
        set_iv(w, 1'b0);
        op1 = a;
        check("consume_ready", {127'b0, rdy(w)}, 128'd1);
        check("consume_valid", {127'b0, vld(w)}, 128'd0);
        check("retain_res", res(w), er);
    endtask

    initial begin
        logic [127:0] ones, smax, smin, ra, rb;
        int           sel;
        vectors     = 0;
        miscompares = 0;
        ones  = '1;
        smax  = {1'b0, {127{1'b1}}};
        smin  = {1'b1, 127'b0};
        rst_n = 1'b0;
        iv128 = 1'b0;
        iv32  = 1'b0;
        or128 = 1'b0;
        or32  = 1'b0;
        op1   = '0;
        op2   = '0;
        cin   = 1'b0;
        sub   = 1'b0;

        // Reset held for three cycles
        repeat (3) begin
            @(posedge clk);
            #1;
            check("rst_in_ready", {127'b0, rdy128}, 128'd1);
        end
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_valid", {127'b0, vld128}, 128'd0);
        check("rst_res", res128, 128'd0);
        check("rst_cout", {127'b0, cout128}, 128'd0);
        check("rst_ovf", {127'b0, ovf128}, 128'd0);
        check("rst_res32", {96'b0, res32}, 128'd0);
        @(posedge clk);
        #1;

        // Directed corners
        run_op(128, ones, 128'd1, 1'b0, 1'b0, 0);
        run_op(128, 128'd0, 128'd1, 1'b0, 1'b1, 0);
        run_op(128, smax, 128'd1, 1'b0, 1'b0, 0);
        run_op(128, smin, 128'd1, 1'b0, 1'b1, 0);
        run_op(128, 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210,
               128'h0000_0000_ffff_ffff_ffff_ffff_0000_0001, 1'b1, 1'b0, 5);
        run_op(128, 128'd5, 128'd3, 1'b1, 1'b1, 0);
        run_op(32, {96'b0, 32'hffff_ffff}, 128'd1, 1'b0, 1'b0, 0);
        run_op(32, {96'b0, 32'h7fff_ffff}, 128'd0, 1'b1, 1'b0, 2);
        run_op(32, {96'b0, 32'h8000_0000}, 128'd0, 1'b1, 1'b1, 0);

        // Reset while the 128-bit unit is mid-CALC (counter at 2)
        op1 = ones;
        op2 = ones;
        cin = 1'b1;
        sub = 1'b0;
        iv128 = 1'b1;
        @(posedge clk);
        #1;
        iv128 = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        #1;
        check("midrst_res", res128, 128'd0);
        check("midrst_cout", {127'b0, cout128}, 128'd0);
        check("midrst_ovf", {127'b0, ovf128}, 128'd0);
        check("midrst_valid", {127'b0, vld128}, 128'd0);
        check("midrst_ready", {127'b0, rdy128}, 128'd1);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_op(128, 128'd7, 128'd9, 1'b0, 1'b0, 0);

        // Random operations at both sizes
        for (int n = 0; n < 400; n++) begin
            sel = $urandom_range(0, 7);
            ra  = {$urandom, $urandom, $urandom, $urandom};
            rb  = {$urandom, $urandom, $urandom, $urandom};
            if (sel == 0) ra = ones;
            if (sel == 1) rb = smax;
            if (sel == 2) ra = smin;
            if (sel == 3) rb = '0;
            if (n < 200) begin
                run_op(128, ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       $urandom_range(0, 2));
            end else begin
                if (sel == 0) ra = 128'hffff_ffff;
                if (sel == 1) rb = 128'h7fff_ffff;
                if (sel == 2) ra = 128'h8000_0000;
                run_op(32, ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       $urandom_range(0, 2));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
